adc_sample_averager: RTL and testbench
======================================

Name: adc_sample_averager

Overview:
- Sits directly downstream of ADC_control.
- Consumes its Valid_Data byte and ADC_ready strobe, and accumulates a window of 2^LOG2_N samples.
- At the end of each window it emits the truncated mean, the window minimum and the window maximum, with a one-cycle valid pulse and a wrapping window counter.
- Provides the reduced-rate, noise-averaged data path toward the PS/display logic on the ZCU102.

Parameters:
- LOG2_N, 2, log2 of window length. Legal range 0..8. N = 2^LOG2_N samples per window; 0 means pass-through.
- WIN_CNT_W, 16, width of the completed-window counter.

Ports:
- clk_100M  input  1  system clock, 100 MHz, all logic on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- ADC_ready  input  1  sample-ready from ADC_control; level may stay high for several cycles
- Valid_Data  input  8  unsigned sample from ADC_control, stable while ADC_ready = 1
- enable  input  1  1 = accept samples; 0 = ignore strobes and hold the partial window
- clear  input  1  synchronous: discard the partial window and restart counting
- avg_data  output  8  mean of the last completed window, truncated toward zero
- min_data  output  8  minimum sample of the last completed window
- max_data  output  8  maximum sample of the last completed window
- avg_valid  output  1  one-cycle pulse when the outputs above update
- sample_cnt  output  LOG2_N+1  samples held in the current partial window (0..N-1)
- win_count  output  WIN_CNT_W  completed windows since reset; wraps modulo 2^WIN_CNT_W

Behaviour:
- Reset (reset = 0, async):
  - All outputs = 0.
  - Internal registers cleared: accumulator, running min = 8'hFF, running max = 8'h00, ready_d = 0.
  - Release is sampled on the next clk_100M edge.
- Edge detect:
  - ready_d registers ADC_ready every cycle.
  - accept = ADC_ready & ~ready_d & enable & ~clear (combinational).
  - One accepted sample per ADC_ready rising edge, regardless of high duration.
  - A rise while enable = 0 is lost; it is not deferred.
- Accumulator:
  - Width 8+LOG2_N. It cannot overflow.
  - run_min and run_max update with the incoming sample on each accept.
- Window state, counted by sample_cnt:
  - ACCUM (sample_cnt < N-1), on accept: acc += Valid_Data, sample_cnt += 1, update min/max.
  - LAST (sample_cnt == N-1), on accept, at the same clock edge:
    - avg_data = (acc + Valid_Data) >> LOG2_N.
    - min_data / max_data = window extremes including this sample.
    - avg_valid = 1.
    - win_count += 1.
    - acc = 0, sample_cnt = 0, run_min = FF, run_max = 00.
- avg_valid timing:
  - Rises on the clock edge that ends the cycle in which accept was high for the Nth sample.
  - Deasserts on the following edge (exactly one cycle).
  - Latency from the ADC_ready rise to avg_valid = 1 cycle.
- LOG2_N = 0: every accept produces avg_data = min_data = max_data = sample, with avg_valid pulsed.
- Output hold: avg_data, min_data and max_data hold between windows and never change except at a window completion.
- Simultaneous events:
  - clear and ADC_ready rise in the same cycle: clear wins. The sample is dropped, the window restarts empty, no avg_valid.
  - clear does not alter avg/min/max/win_count.
  - ready_d still tracks, so a held-high ADC_ready does not re-trigger after clear.
- enable:
  - Deasserting enable mid-window freezes acc, sample_cnt, min and max.
  - Re-enabling continues the same window.
- Async reset mid-window: everything is discarded immediately, including a pending avg_valid.
- win_count wrap: all-ones + 1 -> 0, with no flag.

Test Plan:
- LOG2_N = 2, reset 0 → 1, four ADC_ready rises with data 0x10, 0x20, 0x30, 0x41 → one avg_valid pulse 1 cycle after the 4th rise. avg_data = 0x28 (161 >> 2), min_data = 0x10, max_data = 0x41, win_count = 1, sample_cnt = 0.
- ADC_ready held high 8 cycles with data 0xAB, then low, repeated 4 times → exactly 4 samples counted. avg = min = max = 0xAB, single avg_valid.
- Four samples of 0xFF → avg_data = 0xFF with no overflow (acc = 0x3FC). Then four samples of 0x00 → avg_data = 0x00, min = max = 0x00.
- Two samples 0x50 and 0x60, then clear coincident with a third rise carrying 0x70 → sample_cnt = 0, no avg_valid. Four further samples of 0x04 → avg_data = 0x04, prior output values untouched until then.
- enable = 0 during a rise with data 0x99, inside a window of 0x08 samples → sample_cnt unchanged. Completed window avg_data = 0x08 and max_data = 0x08; 0x99 is excluded.
- Assert reset low between the 3rd and 4th samples → all outputs 0 immediately. After release, the next 4 samples form a fresh window and win_count = 1.

Source files
------------

// File: rtl/adc_sample_averager_if.sv
// rtl/adc_sample_averager_if.sv - sample strobe input and window-statistics output bundle
interface adc_sample_averager_if #(
    parameter int LOG2_N    = 2,
    parameter int WIN_CNT_W = 16
);
    logic                 ADC_ready;
    logic [7:0]           Valid_Data;
    logic                 enable;
    logic                 clear;
    logic [7:0]           avg_data;
    logic [7:0]           min_data;
    logic [7:0]           max_data;
    logic                 avg_valid;
    logic [LOG2_N:0]      sample_cnt;
    logic [WIN_CNT_W-1:0] win_count;

    modport master (
        output ADC_ready, Valid_Data, enable, clear,
        input  avg_data, min_data, max_data, avg_valid, sample_cnt, win_count
    );

    modport slave (
        input  ADC_ready, Valid_Data, enable, clear,
        output avg_data, min_data, max_data, avg_valid, sample_cnt, win_count
    );
endinterface

// File: rtl/adc_sample_averager.sv
// rtl/adc_sample_averager.sv - windowed mean/min/max of ADC samples, one result per 2^LOG2_N strobes
module adc_sample_averager #(
    parameter int LOG2_N    = 2,
    parameter int WIN_CNT_W = 16
) (
    input  logic                  clk_100M,
    input  logic                  reset,
    adc_sample_averager_if.slave  bus
);
    localparam int ACC_W = 8 + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_N) - 1);

    typedef enum logic {ST_ACCUM, ST_LAST} win_state_t;
    // With a one-sample window every accepted sample closes the window.
    localparam win_state_t ST_EMPTY = (LOG2_N == 0) ? ST_LAST : ST_ACCUM;

    win_state_t           state, state_n;
    logic [ACC_W-1:0]     acc, acc_n, sum;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [7:0]           run_min, run_min_n, run_max, run_max_n;
    logic [7:0]           new_min, new_max;
    logic [7:0]           avg_q, avg_n, min_q, min_n, max_q, max_n;
    logic                 valid_q, valid_n;
    logic [WIN_CNT_W-1:0] win_q, win_n;
    logic                 ready_d;
    logic                 accept;

    assign accept  = bus.ADC_ready & ~ready_d & bus.enable & ~bus.clear;
    assign sum     = acc + ACC_W'(bus.Valid_Data);
    assign new_min = (bus.Valid_Data < run_min) ? bus.Valid_Data : run_min;
    assign new_max = (bus.Valid_Data > run_max) ? bus.Valid_Data : run_max;

    always_ff @(posedge clk_100M or negedge reset) begin
        if (!reset) begin
            state   <= ST_EMPTY;
            acc     <= '0;
            cnt     <= '0;
            run_min <= 8'hFF;
            run_max <= 8'h00;
            avg_q   <= 8'h00;
            min_q   <= 8'h00;
            max_q   <= 8'h00;
            valid_q <= 1'b0;
            win_q   <= '0;
            ready_d <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            cnt     <= cnt_n;
            run_min <= run_min_n;
            run_max <= run_max_n;
            avg_q   <= avg_n;
            min_q   <= min_n;
            max_q   <= max_n;
            valid_q <= valid_n;
            win_q   <= win_n;
            ready_d <= bus.ADC_ready;
        end
    end

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        cnt_n     = cnt;
        run_min_n = run_min;
        run_max_n = run_max;
        avg_n     = avg_q;
        min_n     = min_q;
        max_n     = max_q;
        valid_n   = 1'b0;
        win_n     = win_q;

        if (bus.clear) begin
            state_n   = ST_EMPTY;
            acc_n     = '0;
            cnt_n     = '0;
            run_min_n = 8'hFF;
            run_max_n = 8'h00;
        end else if (accept) begin
            if (state == ST_LAST) begin
                avg_n     = 8'(sum >> LOG2_N);
                min_n     = new_min;
                max_n     = new_max;
                valid_n   = 1'b1;
                win_n     = win_q + WIN_CNT_W'(1);
                state_n   = ST_EMPTY;
                acc_n     = '0;
                cnt_n     = '0;
                run_min_n = 8'hFF;
                run_max_n = 8'h00;
            end else begin
                acc_n     = sum;
                cnt_n     = cnt + CNT_W'(1);
                run_min_n = new_min;
                run_max_n = new_max;
                state_n   = (cnt_n == LAST_CNT) ? ST_LAST : ST_ACCUM;
            end
        end
    end

    assign bus.avg_data   = avg_q;
    assign bus.min_data   = min_q;
    assign bus.max_data   = max_q;
    assign bus.avg_valid  = valid_q;
    assign bus.sample_cnt = cnt;
    assign bus.win_count  = win_q;
endmodule

// File: tb/tb_adc_sample_averager.sv
// tb/tb_adc_sample_averager.sv - directed bench with a queue-based window model checked every cycle
module tb_adc_sample_averager;
    localparam int LOG2_N    = 2;
    localparam int WIN_CNT_W = 3;
    localparam int N         = 1 << LOG2_N;

    logic clk_100M = 1'b0;
    logic reset    = 1'b0;

    adc_sample_averager_if #(.LOG2_N(LOG2_N), .WIN_CNT_W(WIN_CNT_W)) bus ();

    adc_sample_averager #(.LOG2_N(LOG2_N), .WIN_CNT_W(WIN_CNT_W)) dut (
        .clk_100M (clk_100M),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk_100M = ~clk_100M;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: samples of the open window kept in a queue; statistics computed when it fills.
    int m_q[$];
    bit m_prev;
    bit m_acc;
    int s, lo, hi;
    int e_avg, e_min, e_max, e_valid, e_cnt, e_win;

    always @(posedge clk_100M) begin
        if (!reset) begin
            m_q.delete();
            m_prev  = 1'b0;
            e_avg   = 0; e_min = 0; e_max = 0;
            e_valid = 0; e_cnt = 0; e_win = 0;
        end else begin
            m_acc   = bus.ADC_ready && !m_prev && bus.enable && !bus.clear;
            m_prev  = bus.ADC_ready;
            e_valid = 0;
            if (bus.clear) begin
                m_q.delete();
            end else if (m_acc) begin
                m_q.push_back(int'(bus.Valid_Data));
                if (m_q.size() == N) begin
                    s = 0; lo = 255; hi = 0;
                    foreach (m_q[i]) begin
                        s += m_q[i];
                        if (m_q[i] < lo) lo = m_q[i];
                        if (m_q[i] > hi) hi = m_q[i];
                    end
                    e_avg   = s / N;
                    e_min   = lo;
                    e_max   = hi;
                    e_valid = 1;
                    e_win   = (e_win + 1) % (1 << WIN_CNT_W);
                    m_q.delete();
                end
            end
            e_cnt = m_q.size();
        end
        #1;
        if (bus.avg_valid === 1'b1) pulses++;
        chk("cyc.avg",   32'(bus.avg_data),   e_avg);
        chk("cyc.min",   32'(bus.min_data),   e_min);
        chk("cyc.max",   32'(bus.max_data),   e_max);
        chk("cyc.valid", 32'(bus.avg_valid),  e_valid);
        chk("cyc.cnt",   32'(bus.sample_cnt), e_cnt);
        chk("cyc.win",   32'(bus.win_count),  e_win);
    end

    task automatic step(input logic rdy, input logic [7:0] d, input logic en, input logic clr);
        @(negedge clk_100M);
        bus.ADC_ready  = rdy;
        bus.Valid_Data = d;
        bus.enable     = en;
        bus.clear      = clr;
    endtask

    task automatic rise(input logic [7:0] d);
        step(1'b1, d, 1'b1, 1'b0);
        step(1'b0, d, 1'b1, 1'b0);
    endtask

    task automatic pin(input string tag, input int v, input int a, input int mn,
                       input int mx, input int w, input int c);
        chk({tag, ".valid"}, 32'(bus.avg_valid),  v);
        chk({tag, ".avg"},   32'(bus.avg_data),   a);
        chk({tag, ".min"},   32'(bus.min_data),   mn);
        chk({tag, ".max"},   32'(bus.max_data),   mx);
        chk({tag, ".win"},   32'(bus.win_count),  w);
        chk({tag, ".cnt"},   32'(bus.sample_cnt), c);
    endtask

    int p0;

    initial begin
        bus.ADC_ready  = 1'b0;
        bus.Valid_Data = 8'h00;
        bus.enable     = 1'b1;
        bus.clear      = 1'b0;
        #2;
        pin("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk_100M);
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        rise(8'h10); rise(8'h20); rise(8'h30); rise(8'h41);
        pin("win1", 1, 'h28, 'h10, 'h41, 1, 0);
        chk("model.win1_avg", e_avg, 'h28);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("win1.pulse_end", 32'(bus.avg_valid), 0);

        p0 = pulses;
        repeat (4) begin
            repeat (8) step(1'b1, 8'hAB, 1'b1, 1'b0);
            step(1'b0, 8'hAB, 1'b1, 1'b0);
        end
        pin("held", 0, 'hAB, 'hAB, 'hAB, 2, 0);
        chk("held.pulses", pulses - p0, 1);

        repeat (4) rise(8'hFF);
        pin("ff", 1, 'hFF, 'hFF, 'hFF, 3, 0);
        repeat (4) rise(8'h00);
        pin("zero", 1, 0, 0, 0, 4, 0);

        rise(8'h50); rise(8'h60);
        step(1'b1, 8'h70, 1'b1, 1'b1);
        step(1'b0, 8'h70, 1'b1, 1'b0);
        pin("clear", 0, 0, 0, 0, 4, 0);
        repeat (4) rise(8'h04);
        pin("after_clr", 1, 4, 4, 4, 5, 0);

        rise(8'h08); rise(8'h08);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b0, 8'h99, 1'b1, 1'b0);
        chk("dis.cnt", 32'(bus.sample_cnt), 2);
        rise(8'h08); rise(8'h08);
        pin("enable", 1, 8, 8, 8, 6, 0);

        repeat (4) rise(8'h80);
        pin("w7", 1, 'h80, 'h80, 'h80, 7, 0);
        rise(8'h01); rise(8'h02); rise(8'h04); rise(8'h08);
        pin("wrap", 1, 3, 1, 8, 0, 0);
        chk("model.wrap", e_win, 0);

        rise(8'h11); rise(8'h22); rise(8'h33);
        chk("pre_rst.cnt", 32'(bus.sample_cnt), 3);
        #2 reset = 1'b0;
        #1 pin("rst_mid", 0, 0, 0, 0, 0, 0);
        @(negedge clk_100M);
        reset = 1'b1;
        rise(8'h01); rise(8'h02); rise(8'h03); rise(8'h06);
        pin("fresh", 1, 3, 1, 6, 1, 0);

        rise(8'h11); rise(8'h22); rise(8'h33); rise(8'h44);
        chk("pend.valid_before", 32'(bus.avg_valid), 1);
        #2 reset = 1'b0;
        #1 pin("rst_pend", 0, 0, 0, 0, 0, 0);
        @(negedge clk_100M);
        reset = 1'b1;
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
